// File: rtl/divisor_pkg.sv
// Shared types and constants for the non-restoring radix-2 divider (divisor_nr4).
package divisor_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    ITERA   = 2'b01,
    CORRIGE = 2'b10,
    FIN     = 2'b11
  } estado_t;

endpackage

// File: rtl/sum_resta_n.sv
// W-bit adder/subtractor shared by the iteration and correction steps of the divider.
module sum_resta_n #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         resta_i,
  output logic [W-1:0] y_o
);

  // Subtraction as a + ~b + 1 keeps a single carry chain for both operations.
  assign y_o = a_i + (b_i ^ {W{resta_i}}) + {{(W-1){1'b0}}, resta_i};

endmodule

// File: rtl/divisor_nr4.sv
// Sequential non-restoring divider: N iterations plus one correction cycle.
// Define DIVISOR_NR4_SIGNO_EN for two's-complement operands (sign fix-up on latch).
module divisor_nr4
  import divisor_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int RETARDO = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto,
  output logic         fin,
  output logic         ocupado,
  output logic         div_cero
);

  localparam int CW = $clog2(N + 1);

  // RETARDO only shapes simulation timing in the legacy model; synthesized registers ignore it.
  if (N < 2 || RETARDO < 0) begin : g_param_check
    $error("divisor_nr4: N must be >= 2 and RETARDO must be >= 0");
  end

  estado_t       estado_q, estado_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N:0]    m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  cociente_q, cociente_d;
  logic [N-1:0]  resto_q, resto_d;
  logic          div_cero_q, div_cero_d;
  logic          fin_q, fin_d;
  logic          ocupado_q, ocupado_d;

  logic [N:0]    a_sh;
  logic [N:0]    sr_a;
  logic          sr_resta;
  logic [N:0]    sr_y;
  logic [N:0]    a_corr;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dsr_mag;
  logic [N-1:0]  coc_fix;
  logic [N-1:0]  res_fix;

`ifdef DIVISOR_NR4_SIGNO_EN
  logic          neg_coc_q, neg_coc_d;
  logic          neg_res_q, neg_res_d;

  function automatic logic [N-1:0] magnitud(input logic [N-1:0] x);
    return x[N-1] ? (~x + {{(N-1){1'b0}}, 1'b1}) : x;
  endfunction

  assign dvd_mag = magnitud(dividendo);
  assign dsr_mag = magnitud(divisor);
  // The most-negative dividend over -1 wraps naturally: |MIN| reads back as MIN.
  assign coc_fix = neg_coc_q ? (~q_q + {{(N-1){1'b0}}, 1'b1}) : q_q;
  assign res_fix = neg_res_q ? (~a_corr[N-1:0] + {{(N-1){1'b0}}, 1'b1}) : a_corr[N-1:0];
`else
  assign dvd_mag = dividendo;
  assign dsr_mag = divisor;
  assign coc_fix = q_q;
  assign res_fix = a_corr[N-1:0];
`endif

  // ITERA operates on the shifted remainder; the operation is chosen by the pre-shift sign.
  assign a_sh     = {a_q[N-1:0], q_q[N-1]};
  assign sr_a     = (estado_q == ITERA) ? a_sh : a_q;
  assign sr_resta = (estado_q == ITERA) && !a_q[N];
  assign a_corr   = a_q[N] ? sr_y : a_q;

  sum_resta_n #(.W(N + 1)) u_sum_resta (
    .a_i     (sr_a),
    .b_i     (m_q),
    .resta_i (sr_resta),
    .y_o     (sr_y)
  );

  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    estado_d   = estado_q;
    a_d        = a_q;
    q_d        = q_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    div_cero_d = div_cero_q;
`ifdef DIVISOR_NR4_SIGNO_EN
    neg_coc_d  = neg_coc_q;
    neg_res_d  = neg_res_q;
`endif

    unique case (estado_q)
      REPOSO: begin
        if (inicio) begin
          if (divisor == '0) begin
            estado_d   = FIN;
            div_cero_d = 1'b1;
            cociente_d = '1;
            resto_d    = dividendo;
          end else begin
            estado_d = ITERA;
            a_d      = '0;
            q_d      = dvd_mag;
            m_d      = {1'b0, dsr_mag};
            cnt_d    = CW'(N);
`ifdef DIVISOR_NR4_SIGNO_EN
            neg_coc_d = dividendo[N-1] ^ divisor[N-1];
            neg_res_d = dividendo[N-1];
`endif
          end
        end
      end

      ITERA: begin
        a_d   = sr_y;
        q_d   = {q_q[N-2:0], ~sr_y[N]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          estado_d = CORRIGE;
        end
      end

      CORRIGE: begin
        a_d        = a_corr;
        cociente_d = coc_fix;
        resto_d    = res_fix;
        div_cero_d = 1'b0;
        estado_d   = FIN;
      end

      FIN: begin
        estado_d = REPOSO;
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase

    // Flags are registered from the next state so they line up exactly with the state.
    fin_d     = (estado_d == FIN);
    ocupado_d = (estado_d != REPOSO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= REPOSO;
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      cociente_q <= '0;
      resto_q    <= '0;
      div_cero_q <= 1'b0;
      fin_q      <= 1'b0;
      ocupado_q  <= 1'b0;
`ifdef DIVISOR_NR4_SIGNO_EN
      neg_coc_q  <= 1'b0;
      neg_res_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      estado_q   <= estado_d;
      a_q        <= a_d;
      q_q        <= q_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      div_cero_q <= div_cero_d;
      fin_q      <= fin_d;
      ocupado_q  <= ocupado_d;
`ifdef DIVISOR_NR4_SIGNO_EN
      neg_coc_q  <= neg_coc_d;
      neg_res_q  <= neg_res_d;
`endif
    end
  end

  assign cociente = cociente_q;
  assign resto    = resto_q;
  assign div_cero = div_cero_q;
  assign fin      = fin_q;
  assign ocupado  = ocupado_q;

endmodule
